// File: rtl/execute_stage.sv
// Execute stage: single-cycle ALU, address generation and a
// WIDTH-cycle shift-add multiplier that stalls decode while busy.
module execute_stage #(
    parameter int         WIDTH    = 16,
    parameter logic [3:0] NOP_CODE = 4'hF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_id,
    input  logic [3:0]       control_id,
    input  logic [WIDTH-1:0] op_a_id,
    input  logic [WIDTH-1:0] op_b_id,
    input  logic [WIDTH-1:0] reg_data_id,
    input  logic [4:0]       dest_reg_index_id,
    input  logic             dest_reg_write_en_id,
    output logic [3:0]       control_ex,
    output logic [WIDTH-1:0] result_ex,
    output logic [WIDTH-1:0] reg_data_ex,
    output logic [4:0]       dest_reg_index_ex,
    output logic             dest_reg_write_en_ex,
    output logic             stall_ex
);

    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = $clog2(WIDTH) + 1;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_SLL   = 4'd5;
    localparam logic [3:0] OP_SRL   = 4'd6;
    localparam logic [3:0] OP_SRA   = 4'd7;
    localparam logic [3:0] OP_MUL   = 4'd8;
    localparam logic [3:0] OP_LOAD  = 4'd9;
    localparam logic [3:0] OP_STORE = 4'd10;

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        MUL_BUSY
    } state_t;

    state_t state, state_n;

    logic [WIDTH-1:0] mcand, mcand_n;
    logic [WIDTH-1:0] mplier, mplier_n;
    logic [WIDTH-1:0] acc, acc_n;
    logic [CW-1:0]    count, count_n;
    logic [4:0]       mul_dest, mul_dest_n;
    logic             mul_we, mul_we_n;

    logic [3:0]       control_n;
    logic [WIDTH-1:0] result_n;
    logic [WIDTH-1:0] reg_data_n;
    logic [4:0]       dest_index_n;
    logic             dest_we_n;
    logic             stall_n;

    logic [WIDTH-1:0] alu_res;
    logic [SHW-1:0]   shamt;
    logic             no_write;
    logic [WIDTH-1:0] acc_step;

    assign shamt    = op_b_id[SHW-1:0];
    assign acc_step = mplier[0] ? acc + mcand : acc;

    // Stores and the unused opcodes never write the register file.
    assign no_write = (control_id == OP_STORE) || (control_id > OP_STORE);

    always_comb begin
        alu_res = '0;
        unique case (control_id)
            OP_ADD:   alu_res = op_a_id + op_b_id;
            OP_SUB:   alu_res = op_a_id - op_b_id;
            OP_AND:   alu_res = op_a_id & op_b_id;
            OP_OR:    alu_res = op_a_id | op_b_id;
            OP_XOR:   alu_res = op_a_id ^ op_b_id;
            OP_SLL:   alu_res = op_a_id << shamt;
            OP_SRL:   alu_res = op_a_id >> shamt;
            OP_SRA:   alu_res = $signed(op_a_id) >>> shamt;
            OP_LOAD:  alu_res = op_a_id + op_b_id;
            OP_STORE: alu_res = op_a_id + op_b_id;
            default:  alu_res = '0;
        endcase
    end

    always_comb begin
        state_n      = state;
        mcand_n      = mcand;
        mplier_n     = mplier;
        acc_n        = acc;
        count_n      = count;
        mul_dest_n   = mul_dest;
        mul_we_n     = mul_we;
        control_n    = NOP_CODE;
        result_n     = '0;
        reg_data_n   = '0;
        dest_index_n = '0;
        dest_we_n    = 1'b0;
        stall_n      = 1'b0;

        case (state)
            IDLE: begin
                if (valid_id && control_id == OP_MUL) begin
                    mcand_n    = op_a_id;
                    mplier_n   = op_b_id;
                    acc_n      = '0;
                    count_n    = '0;
                    mul_dest_n = dest_reg_index_id;
                    mul_we_n   = dest_reg_write_en_id;
                    stall_n    = 1'b1;
                    state_n    = MUL_BUSY;
                end else if (valid_id) begin
                    control_n    = control_id;
                    result_n     = alu_res;
                    reg_data_n   = reg_data_id;
                    dest_index_n = dest_reg_index_id;
                    dest_we_n    = dest_reg_write_en_id && !no_write;
                end
            end
            MUL_BUSY: begin
                acc_n    = acc_step;
                mcand_n  = mcand << 1;
                mplier_n = mplier >> 1;
                count_n  = count + 1'b1;
                if (count == LAST) begin
                    control_n    = OP_MUL;
                    result_n     = acc_step;
                    dest_index_n = mul_dest;
                    dest_we_n    = mul_we;
                    state_n      = IDLE;
                end else begin
                    stall_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state                <= IDLE;
            mcand                <= '0;
            mplier               <= '0;
            acc                  <= '0;
            count                <= '0;
            mul_dest             <= '0;
            mul_we               <= 1'b0;
            control_ex           <= NOP_CODE;
            result_ex            <= '0;
            reg_data_ex          <= '0;
            dest_reg_index_ex    <= '0;
            dest_reg_write_en_ex <= 1'b0;
            stall_ex             <= 1'b0;
        end else begin
            state                <= state_n;
            mcand                <= mcand_n;
            mplier               <= mplier_n;
            acc                  <= acc_n;
            count                <= count_n;
            mul_dest             <= mul_dest_n;
            mul_we               <= mul_we_n;
            control_ex           <= control_n;
            result_ex            <= result_n;
            reg_data_ex          <= reg_data_n;
            dest_reg_index_ex    <= dest_index_n;
            dest_reg_write_en_ex <= dest_we_n;
            stall_ex             <= stall_n;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: ALU ops, bubbles, multiply
// timing/stall, back-to-back multiply and reset abort.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_id;
    logic [3:0]  control_id;
    logic [15:0] op_a_id;
    logic [15:0] op_b_id;
    logic [15:0] reg_data_id;
    logic [4:0]  dest_reg_index_id;
    logic        dest_reg_write_en_id;
    logic [3:0]  control_ex;
    logic [15:0] result_ex;
    logic [15:0] reg_data_ex;
    logic [4:0]  dest_reg_index_ex;
    logic        dest_reg_write_en_ex;
    logic        stall_ex;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    execute_stage dut (
        .clk                  (clk),
        .reset                (reset),
        .valid_id             (valid_id),
        .control_id           (control_id),
        .op_a_id              (op_a_id),
        .op_b_id              (op_b_id),
        .reg_data_id          (reg_data_id),
        .dest_reg_index_id    (dest_reg_index_id),
        .dest_reg_write_en_id (dest_reg_write_en_id),
        .control_ex           (control_ex),
        .result_ex            (result_ex),
        .reg_data_ex          (reg_data_ex),
        .dest_reg_index_ex    (dest_reg_index_ex),
        .dest_reg_write_en_ex (dest_reg_write_en_ex),
        .stall_ex             (stall_ex)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] c,
                         input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] d, input logic [4:0] idx,
                         input logic we);
        valid_id             = v;
        control_id           = c;
        op_a_id              = a;
        op_b_id              = b;
        reg_data_id          = d;
        dest_reg_index_id    = idx;
        dest_reg_write_en_id = we;
    endtask

    task automatic chk_out(input string tag, input logic [3:0] c,
                           input logic [15:0] r, input logic [15:0] d,
                           input logic [4:0] idx, input logic we,
                           input logic st);
        chk({tag, ".ctl"}, 32'(control_ex), 32'(c));
        chk({tag, ".res"}, 32'(result_ex), 32'(r));
        chk({tag, ".rd"}, 32'(reg_data_ex), 32'(d));
        chk({tag, ".idx"}, 32'(dest_reg_index_ex), 32'(idx));
        chk({tag, ".we"}, 32'(dest_reg_write_en_ex), 32'(we));
        chk({tag, ".stall"}, 32'(stall_ex), 32'(st));
    endtask

    // Issues a MUL (accepted at the next edge), then counts stall cycles
    // with a bounded wait and checks the emitted product.
    task automatic run_mul(input string tag, input logic [15:0] a,
                           input logic [15:0] b, input logic [4:0] idx,
                           input logic [15:0] exp);
        int n;
        drive(1'b1, 4'd8, a, b, 16'h5555, idx, 1'b1);
        step();
        n = 0;
        while (stall_ex && n < 40) begin
            chk({tag, ".bubble"}, 32'(control_ex), 32'hF);
            n++;
            step();
        end
        chk({tag, ".stalls"}, 32'(n), 32'd16);
        chk_out(tag, 4'd8, exp, 16'h0, idx, 1'b1, 1'b0);
    endtask

    typedef struct {
        logic [3:0]  c;
        logic [15:0] a;
        logic [15:0] b;
        logic        we;
        logic [15:0] r;
        logic        wex;
    } vec_t;

    vec_t vecs[9];

    initial begin
        vecs[0] = '{4'd1, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b1};
        vecs[1] = '{4'd2, 16'hF0F0, 16'hFF00, 1'b1, 16'hF000, 1'b1};
        vecs[2] = '{4'd3, 16'hF0F0, 16'h0F00, 1'b1, 16'hFFF0, 1'b1};
        vecs[3] = '{4'd4, 16'hAAAA, 16'hFFFF, 1'b1, 16'h5555, 1'b1};
        vecs[4] = '{4'd5, 16'h0001, 16'h001F, 1'b1, 16'h8000, 1'b1};
        vecs[5] = '{4'd6, 16'h8000, 16'h0004, 1'b1, 16'h0800, 1'b1};
        vecs[6] = '{4'd7, 16'h4000, 16'h0002, 1'b1, 16'h1000, 1'b1};
        vecs[7] = '{4'd9, 16'h1000, 16'h0010, 1'b1, 16'h1010, 1'b1};
        vecs[8] = '{4'd12, 16'h1234, 16'h1111, 1'b1, 16'h0000, 1'b0};

        reset = 1'b1;
        drive(1'b0, 4'd0, 16'h0, 16'h0, 16'h0, 5'd0, 1'b0);
        step();
        step();
        chk_out("rst", 4'hF, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
        reset = 1'b0;
        step();
        chk_out("idle", 4'hF, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);

        drive(1'b1, 4'd0, 16'hFFFF, 16'h0002, 16'h1111, 5'd3, 1'b1);
        step();
        chk_out("add", 4'd0, 16'h0001, 16'h1111, 5'd3, 1'b1, 1'b0);

        drive(1'b1, 4'd7, 16'h8000, 16'h0003, 16'h0, 5'd4, 1'b1);
        step();
        chk_out("sra", 4'd7, 16'hF000, 16'h0, 5'd4, 1'b1, 1'b0);

        drive(1'b1, 4'd10, 16'h0100, 16'h0004, 16'hBEEF, 5'd5, 1'b1);
        step();
        chk_out("store", 4'd10, 16'h0104, 16'hBEEF, 5'd5, 1'b0, 1'b0);

        for (int i = 0; i < 9; i++) begin
            drive(1'b1, vecs[i].c, vecs[i].a, vecs[i].b, 16'h00AA, 5'd9,
                  vecs[i].we);
            step();
            chk_out($sformatf("alu%0d", i), vecs[i].c, vecs[i].r,
                    16'h00AA, 5'd9, vecs[i].wex, 1'b0);
        end

        drive(1'b0, 4'd0, 16'h7777, 16'h7777, 16'h7777, 5'd1, 1'b1);
        step();
        chk_out("bubble", 4'hF, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);

        // MUL at E0 with an ADD held behind it by decode.
        drive(1'b1, 4'd8, 16'h0123, 16'h0045, 16'h5555, 5'd7, 1'b1);
        step();
        drive(1'b1, 4'd0, 16'h0001, 16'h0001, 16'h0033, 5'd2, 1'b1);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("mul1.stall%0d", i), 32'(stall_ex), 32'd1);
            chk($sformatf("mul1.ctl%0d", i), 32'(control_ex), 32'hF);
            chk($sformatf("mul1.we%0d", i), 32'(dest_reg_write_en_ex), 32'd0);
            step();
        end
        chk_out("mul1", 4'd8, 16'h4E6F, 16'h0, 5'd7, 1'b1, 1'b0);
        step();
        chk_out("held_add", 4'd0, 16'h0002, 16'h0033, 5'd2, 1'b1, 1'b0);

        // Back-to-back multiplies, no gap between them.
        run_mul("mul_ff", 16'hFFFF, 16'hFFFF, 5'd10, 16'h0001);
        run_mul("mul_zero", 16'h0000, 16'h1234, 5'd11, 16'h0000);
        run_mul("mul_b2b", 16'h0003, 16'h0005, 5'd12, 16'h000F);

        // Reset lands on E8 of a multiply.
        drive(1'b1, 4'd8, 16'h00FF, 16'h00FF, 16'h0, 5'd13, 1'b1);
        step();
        drive(1'b0, 4'd0, 16'h0, 16'h0, 16'h0, 5'd0, 1'b0);
        for (int i = 0; i < 7; i++) step();
        chk("abort.pre_stall", 32'(stall_ex), 32'd1);
        reset = 1'b1;
        step();
        chk_out("abort", 4'hF, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
        reset = 1'b0;
        drive(1'b1, 4'd0, 16'h0005, 16'h0006, 16'h0, 5'd6, 1'b1);
        step();
        chk_out("post_rst_add", 4'd0, 16'h000B, 16'h0, 5'd6, 1'b1, 1'b0);
        drive(1'b0, 4'd0, 16'h0, 16'h0, 16'h0, 5'd0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step();
            chk($sformatf("no_stale%0d", i), 32'(control_ex), 32'hF);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
